// File: rtl/rc4_prga_stream_decryptor.sv
// RC4 PRGA stream decryptor: generates the RC4 keystream from an S-box held in an
// external single-port synchronous RAM and XORs it with ciphertext from a ROM.
// Plaintext bytes go out over a valid/ready handshake.
//
// Optional feature macro: RC4_PRGA_EARLY_ABORT_EN. When it is defined, the run ends
// early (abort_o=1, done_o=1) on the first plaintext byte that is neither 'a'..'z'
// nor a space. When it is undefined, abort_o is always 0 and every byte is emitted.
//
// Ports:
//   clk_i, rst_ni    clock; asynchronous active-low reset
//   start_i          level; sampled in idle/done to begin a run
//   msg_len_i        bytes to decrypt; latched at start and clamped to MSG_DEP
//   s_addr_o         S RAM address
//   s_wdata_o        S RAM write data
//   s_we_o           S RAM write enable
//   s_rdata_i        S RAM read data, valid 1 cycle after the address
//   rom_addr_o       ciphertext ROM address
//   rom_rdata_i      ciphertext ROM data, valid 1 cycle after the address
//   out_data_o       plaintext byte
//   out_idx_o        index of out_data_o
//   out_valid_o      out_data_o/out_idx_o valid
//   out_ready_i      consumer accepts the byte
//   busy_o           run in progress
//   done_o           run finished; held until the next start
//   abort_o          run ended early on a non-text byte
module rc4_prga_stream_decryptor #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MSG_DEP    = 32,
   parameter int unsigned LEN_W      = $clog2(MSG_DEP + 1),
   parameter int unsigned IDX_W      = $clog2(MSG_DEP)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [LEN_W-1:0]      msg_len_i,
   output logic [DATA_WIDTH-1:0] s_addr_o,
   output logic [DATA_WIDTH-1:0] s_wdata_o,
   output logic                  s_we_o,
   input  logic [DATA_WIDTH-1:0] s_rdata_i,
   output logic [IDX_W-1:0]      rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_rdata_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic [IDX_W-1:0]      out_idx_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  abort_o
);

   typedef enum logic [3:0] {
      StIdle, StRdI, StWtI, StLdI, StWtJ, StLdJ, StWrJ,
      StWrI, StRdF, StWtF, StXor, StEmit, StDone
   } state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] i_q, j_q, si_q, sj_q;
   logic [IDX_W-1:0]      k_q;
   logic [LEN_W-1:0]      len_q;
   logic [DATA_WIDTH-1:0] s_addr_q, s_wdata_q, out_data_q;
   logic                  s_we_q, out_valid_q, busy_q, done_q, abort_q;
   logic [IDX_W-1:0]      rom_addr_q, out_idx_q;

   logic [DATA_WIDTH-1:0] plain;
   logic [LEN_W-1:0]      k_inc;
   logic [LEN_W-1:0]      len_clamped;
   logic                  bad_byte;

   assign plain       = s_rdata_i ^ rom_rdata_i;
   assign k_inc       = LEN_W'(k_q) + LEN_W'(1);
   assign len_clamped = (msg_len_i > LEN_W'(MSG_DEP)) ? LEN_W'(MSG_DEP) : msg_len_i;

`ifdef RC4_PRGA_EARLY_ABORT_EN
   assign bad_byte = !(((plain >= DATA_WIDTH'('h61)) && (plain <= DATA_WIDTH'('h7A))) ||
                       (plain == DATA_WIDTH'('h20)));
`else
   assign bad_byte = 1'b0;
`endif

   // RAM/ROM controls are registered: the address set while in a state is on the bus
   // during the following state, so the read data lands two states later (WT_* covers
   // the gap). The two swap writes therefore hit the RAM before the S[si+sj] read.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         i_q         <= '0;
         j_q         <= '0;
         si_q        <= '0;
         sj_q        <= '0;
         k_q         <= '0;
         len_q       <= '0;
         s_addr_q    <= '0;
         s_wdata_q   <= '0;
         s_we_q      <= 1'b0;
         rom_addr_q  <= '0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start_i) begin
                  len_q   <= len_clamped;
                  i_q     <= '0;
                  j_q     <= '0;
                  k_q     <= '0;
                  abort_q <= 1'b0;
                  if (len_clamped == '0) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= StDone;
                  end else begin
                     done_q  <= 1'b0;
                     busy_q  <= 1'b1;
                     state_q <= StRdI;
                  end
               end
            end
            StRdI: begin
               i_q      <= i_q + DATA_WIDTH'(1);
               s_addr_q <= i_q + DATA_WIDTH'(1);
               state_q  <= StWtI;
            end
            StWtI: state_q <= StLdI;
            StLdI: begin
               si_q     <= s_rdata_i;
               j_q      <= j_q + s_rdata_i;
               s_addr_q <= j_q + s_rdata_i;
               state_q  <= StWtJ;
            end
            StWtJ: state_q <= StLdJ;
            StLdJ: begin
               sj_q    <= s_rdata_i;
               state_q <= StWrJ;
            end
            // When i==j both writes store the same value, so the swap stays correct.
            StWrJ: begin
               s_addr_q  <= j_q;
               s_wdata_q <= si_q;
               s_we_q    <= 1'b1;
               state_q   <= StWrI;
            end
            StWrI: begin
               s_addr_q   <= i_q;
               s_wdata_q  <= sj_q;
               s_we_q     <= 1'b1;
               rom_addr_q <= k_q;
               state_q    <= StRdF;
            end
            StRdF: begin
               s_addr_q <= si_q + sj_q;
               s_we_q   <= 1'b0;
               state_q  <= StWtF;
            end
            StWtF: state_q <= StXor;
            StXor: begin
               out_data_q <= plain;
               out_idx_q  <= k_q;
               if (bad_byte) begin
                  abort_q <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StDone;
               end else begin
                  out_valid_q <= 1'b1;
                  state_q     <= StEmit;
               end
            end
            StEmit: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  k_q         <= k_q + IDX_W'(1);
                  if (k_inc == len_q) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= StDone;
                  end else begin
                     state_q <= StRdI;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign s_addr_o    = s_addr_q;
   assign s_wdata_o   = s_wdata_q;
   assign s_we_o      = s_we_q;
   assign rom_addr_o  = rom_addr_q;
   assign out_data_o  = out_data_q;
   assign out_idx_o   = out_idx_q;
   assign out_valid_o = out_valid_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign abort_o     = abort_q;

endmodule

// File: tb/tb_rc4_prga_stream_decryptor.sv
`timescale 1ns/1ps
module tb_rc4_prga_stream_decryptor;
   localparam int DW = 8;
   localparam int MD = 32;
   localparam int LW = $clog2(MD + 1);
   localparam int IW = $clog2(MD);
`ifdef RC4_PRGA_EARLY_ABORT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] msg_len = '0;
   logic [DW-1:0] s_addr, s_wdata, s_rdata, rom_rdata, out_data;
   logic          s_we, out_valid, busy, done, abort;
   logic          out_ready = 1'b1;
   logic [IW-1:0] rom_addr, out_idx;

   always #5 clk = ~clk;

   rc4_prga_stream_decryptor #(.DATA_WIDTH(DW), .MSG_DEP(MD)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .msg_len_i(msg_len),
      .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_we_o(s_we), .s_rdata_i(s_rdata),
      .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata),
      .out_data_o(out_data), .out_idx_o(out_idx), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .busy_o(busy), .done_o(done), .abort_o(abort)
   );

   // Memories and the reference S-box model.
   logic [DW-1:0] ram [256];
   logic [DW-1:0] ms  [256];
   logic [DW-1:0] rom [MD];
   logic          init_load = 1'b0;

   always @(posedge clk) begin
      if (init_load) begin
         for (int x = 0; x < 256; x++) ram[x] <= ms[x];
      end else if (s_we) begin
         ram[s_addr] <= s_wdata;
      end
      s_rdata <= ram[s_addr];
   end

   always @(posedge clk) rom_rdata <= rom[rom_addr];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Output monitor: drives out_ready, records accepted bytes, checks stall stability.
   typedef struct packed {logic [IW-1:0] idx; logic [DW-1:0] data;} ob_t;
   ob_t  got_q[$];
   int   ready_mode = 0;
   int   cyc_ctr = 0;
   bit   stall_prev = 1'b0;
   ob_t  held;

   always @(negedge clk) begin
      cyc_ctr++;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (cyc_ctr % 3 == 0);
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (stall_prev && rst_n) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_data", {out_idx, out_data}, held);
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_idx, out_data};
      if (out_valid && out_ready) got_q.push_back({out_idx, out_data});
   end

   // Reference model: plain RC4 PRGA over the model S-box.
   logic [DW-1:0] exp_q[$];
   bit            exp_abort;
   int            exp_abort_idx;

   function automatic bit is_text(input logic [7:0] p);
      return (p >= 8'h61 && p <= 8'h7A) || p == 8'h20;
   endfunction

   task automatic model_run(input int len);
      int i, j, n;
      logic [7:0] t, ks, p;
      i = 0; j = 0;
      exp_q.delete();
      exp_abort = 1'b0;
      exp_abort_idx = 0;
      n = (len > MD) ? MD : len;
      for (int k = 0; k < n; k++) begin
         i = (i + 1) % 256;
         j = (j + int'(ms[i])) % 256;
         t = ms[i]; ms[i] = ms[j]; ms[j] = t;
         ks = ms[(int'(ms[i]) + int'(ms[j])) % 256];
         p = ks ^ rom[k];
         if (EARLY && !is_text(p)) begin
            exp_abort = 1'b1;
            exp_abort_idx = k;
            break;
         end
         exp_q.push_back(p);
      end
   endtask

   task automatic init_s(input bit rnd);
      int y;
      logic [7:0] t;
      for (int x = 0; x < 256; x++) ms[x] = 8'(x);
      if (rnd) begin
         for (int x = 255; x > 0; x--) begin
            y = $urandom_range(0, x);
            t = ms[x]; ms[x] = ms[y]; ms[y] = t;
         end
      end
      @(negedge clk); init_load = 1'b1;
      @(negedge clk); init_load = 1'b0;
   endtask

   task automatic do_run(input int len, input int mode, output int cyc);
      got_q.delete();
      ready_mode = mode;
      @(negedge clk);
      msg_len = LW'(len);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      chk("run_done", done, 1);
   endtask

   task automatic check_result(input string tag, input int mode, input int cyc);
      int bad, exp_c;
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      for (int b = 0; b < got_q.size() && b < exp_q.size(); b++) begin
         chk($sformatf("%s_data%0d", tag, b), got_q[b].data, exp_q[b]);
         chk($sformatf("%s_idx%0d", tag, b), got_q[b].idx, b);
      end
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_abort"}, abort, exp_abort);
      if (exp_abort) chk({tag, "_abort_idx"}, out_idx, exp_abort_idx);
      bad = 0;
      for (int x = 0; x < 256; x++) if (ram[x] !== ms[x]) bad++;
      chk({tag, "_sbox_mismatches"}, bad, 0);
      if (mode == 0) begin
         exp_c = exp_abort ? 11 * exp_abort_idx + 10 : 11 * exp_q.size();
         chk({tag, "_cycles"}, cyc, exp_c);
      end
   endtask

   // Directed vectors (identity S).
   typedef struct {
      int len; int mode;
      logic [7:0] r0, r1, r2;
      int n_exp;
      logic [7:0] e0, e1, e2;
      bit ab; int ab_idx;
   } vec_t;
   vec_t tbl[3];

   task automatic run_vec(input int t, input string tag);
      vec_t v;
      logic [7:0] ev[3];
      int cyc;
      v = tbl[t];
      init_s(1'b0);
      for (int x = 0; x < MD; x++) rom[x] = 8'h00;
      rom[0] = v.r0; rom[1] = v.r1; rom[2] = v.r2;
      model_run(v.len);
      ev[0] = v.e0; ev[1] = v.e1; ev[2] = v.e2;
      exp_q.delete();
      for (int b = 0; b < v.n_exp; b++) exp_q.push_back(ev[b]);
      exp_abort = v.ab;
      exp_abort_idx = v.ab_idx;
      do_run(v.len, v.mode, cyc);
      check_result(tag, v.mode, cyc);
   endtask

   initial begin
      int cyc, len;
`ifdef RC4_PRGA_EARLY_ABORT_EN
      tbl[0] = '{3, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1'b1, 0};
      tbl[2] = '{2, 0, 8'h63, 8'h05, 8'h00, 1, 8'h61, 8'h00, 8'h00, 1'b1, 1};
`else
      tbl[0] = '{3, 0, 8'h00, 8'h00, 8'h00, 3, 8'h02, 8'h05, 8'h07, 1'b0, 0};
      tbl[2] = '{2, 0, 8'h63, 8'h05, 8'h00, 2, 8'h61, 8'h00, 8'h00, 1'b0, 0};
`endif
      tbl[1] = '{3, 1, 8'h22, 8'h25, 8'h27, 3, 8'h20, 8'h20, 8'h20, 1'b0, 0};

      for (int x = 0; x < MD; x++) rom[x] = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {s_addr, s_wdata, s_we, rom_addr, out_data, out_idx,
                            out_valid, busy, done, abort}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {out_valid, busy, done, abort}, 0);

      for (int t = 0; t < 3; t++) begin
         run_vec(t, $sformatf("vec%0d", t));
`ifndef RC4_PRGA_EARLY_ABORT_EN
         if (t == 0) begin
            chk("vec0_s2", ram[2], 8'h03);
            chk("vec0_s3", ram[3], 8'h05);
            chk("vec0_s5", ram[5], 8'h02);
         end
`endif
      end

      // Zero-length message.
      init_s(1'b0);
      model_run(0);
      do_run(0, 0, cyc);
      check_result("len0", 0, cyc);
      chk("len0_within_2", cyc <= 2, 1);

      // Reset during the first swap write of byte 1.
      init_s(1'b0);
      for (int x = 0; x < MD; x++) rom[x] = 8'h00;
      ready_mode = 0;
      @(negedge clk); msg_len = LW'(3); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (16) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_outputs", {s_addr, s_wdata, s_we, rom_addr, out_data, out_idx,
                                   out_valid, busy, done, abort}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrun_reset_idle", {out_valid, busy, done, abort}, 0);
      run_vec(0, "rerun");

      // Randomised runs against the model.
      for (int r = 0; r < 5; r++) begin
         init_s(1'b1);
         for (int x = 0; x < MD; x++) rom[x] = 8'($urandom_range(0, 255));
         len = (r == 4) ? MD + 5 : $urandom_range(1, MD);
         model_run(len);
         do_run(len, (r == 0) ? 0 : 2, cyc);
         check_result($sformatf("rand%0d", r), (r == 0) ? 0 : 2, cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/rc4_prga_stream_decryptor.md
Name: rc4_prga_stream_decryptor

Overview:
- Parametrised successor to the RC4 third-loop decryptor (PRGA + XOR). Runs after the S-init and key-schedule FSMs and streams plaintext bytes to the checker FSM.
- Accesses S through a single-port synchronous RAM with 1-cycle read latency, not a registered copy of S. Fetches ciphertext from a 1-cycle-latency ROM.
- Adds a runtime message length, a valid/ready output handshake, and optional early abort on non-plaintext bytes.

Parameters:
- DATA_WIDTH, 8, bits per S word and message byte. S depth = 2**DATA_WIDTH.
- MSG_DEP, 32, maximum message length in bytes.
- LEN_W, $clog2(MSG_DEP+1), width of msg_len.
- IDX_W, $clog2(MSG_DEP), width of the ROM address and out_idx.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  level; sampled in IDLE/DONE to begin a run
- msg_len  input  LEN_W  bytes to decrypt; latched when start is sampled
- s_addr  output  DATA_WIDTH  S RAM address
- s_wdata  output  DATA_WIDTH  S RAM write data
- s_we  output  1  S RAM write enable
- s_rdata  input  DATA_WIDTH  S RAM read data, valid 1 cycle after s_addr
- rom_addr  output  IDX_W  ciphertext ROM address
- rom_rdata  input  DATA_WIDTH  ciphertext byte, valid 1 cycle after rom_addr
- out_data  output  DATA_WIDTH  plaintext byte
- out_idx  output  IDX_W  index k of out_data
- out_valid  output  1  out_data/out_idx valid
- out_ready  input  1  consumer accepts the byte
- busy  output  1  run in progress
- done  output  1  run finished; held until next start
- abort  output  1  run ended early (optional feature)

Behaviour:
- Reset: all outputs, i, j and k are 0; state is IDLE. A reset asserted mid-run returns the block to IDLE immediately. No partial write completes after reset.
- Arithmetic: i, j and f-address are DATA_WIDTH-bit and wrap mod 2**DATA_WIDTH. k is IDX_W-bit.
- Start in IDLE or DONE: latch msg_len; clear i, j, k, done and abort; set busy=1.
  - If msg_len==0: go to DONE (done=1, busy=0, no out_valid).
  - If msg_len>MSG_DEP: clamp to MSG_DEP.
- start while busy is ignored.
- States per byte, one cycle each unless noted:
  - RD_I: i<=i+1; s_addr=i+1.
  - WT_I.
  - LD_I: si<=s_rdata; j<=j+s_rdata; s_addr=j+s_rdata.
  - WT_J.
  - LD_J: sj<=s_rdata.
  - WR_J: s_addr=j, s_wdata=si, s_we=1.
  - WR_I: s_addr=i, s_wdata=sj, s_we=1; rom_addr=k.
  - RD_F: s_addr=si+sj; s_we=0.
  - WT_F.
  - XOR: out_data<=s_rdata^rom_rdata; out_idx<=k.
  - EMIT: out_valid=1; hold until out_ready. On the accept cycle: out_valid<=0, k<=k+1. Go to DONE if k+1==msg_len, else RD_I.
- s_we is high only in WR_J and WR_I. Case i==j is correct by construction: both writes store the same value.
- Latency:
  - First out_valid is high after the 10th rising edge following the edge that samples start.
  - With out_ready held high, throughput is 1 byte per 11 cycles.
  - done rises on the edge after the last accept.
- out_data and out_idx are stable while out_valid=1 and out_ready=0.
- DONE: done=1, busy=0; remain in DONE until start.

Optional Feature:
- Macro: RC4_PRGA_EARLY_ABORT_EN.
- With the macro defined:
  - In XOR, if the plaintext byte is not 0x61..0x7A and not 0x20, that byte is not emitted.
  - Next state is DONE with abort=1 and done=1. abort is held until the next start.
  - out_idx holds the failing k.
- Without the macro: abort is tied to 0 and every byte is emitted.

Test Plan:
- Identity S (S[x]=x), ROM={0x00,0x00,0x00}, msg_len=3, out_ready=1 -> out_data 0x02,0x05,0x07 at out_idx 0,1,2. Afterwards S[2]=3, S[3]=5, S[5]=2. done=1.
- Identity S, ROM={0x22,0x25,0x27}, out_ready toggled 1 of 3 cycles -> 0x20,0x20,0x20. out_data is stable while stalled. No byte is lost or duplicated.
- msg_len=0 -> no out_valid; done=1 within 2 cycles. msg_len=MSG_DEP+5 -> exactly MSG_DEP bytes.
- reset pulsed low during WR_J of byte 1 -> all outputs 0 and state IDLE. A subsequent start with re-initialised S reproduces the first scenario.
- RC4_PRGA_EARLY_ABORT_EN, identity S, ROM={0x63,0x05} -> byte 0 = 0x61 emitted. Byte 1 = 0x00: abort=1, done=1, out_idx=1, no second out_valid.
